// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the MIPS next-PC sequencer.
// Cause codes, default vectors and PC step.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_ADEL = 2'd2
  } cause_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int          PC_STEP       = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/exception logic and the sequencer.
// master: requester side (drives redirects); slave: the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic              jump_reg;
  logic [ADDR_W-1:0] reg_target;
  logic              exception;
  logic              eret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] epc;
  logic [1:0]        cause;
  logic              in_handler;
  logic              flush;

  modport master (
    output stall, branch_taken, branch_offset,
    output jump, jump_target, jump_reg, reg_target,
    output exception, eret,
    input  pc, pc_plus4, epc, cause, in_handler, flush
  );

  modport slave (
    input  stall, branch_taken, branch_offset,
    input  jump, jump_target, jump_reg, reg_target,
    input  exception, eret,
    output pc, pc_plus4, epc, cause, in_handler, flush
  );

endinterface

// File: rtl/pc_sequencer_sign_exten.sv
// Sign extension of a 16-bit MIPS immediate to 32 bits.
// imm: immediate in; ext: sign-extended result.
module sign_exten (
  input  logic [15:0] imm,
  output logic [31:0] ext
);

  assign ext = {{16{imm[15]}}, imm};

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC unit: step, branch, jump, JR, exception vector, ERET, stall.
// clk/reset plain; everything else through pc_sequencer_if.slave.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q, epc_q;
  logic [1:0]        cause_q;
  logic              inh_q, flush_q;

  logic [ADDR_W-1:0] pc_d, epc_d;
  logic [1:0]        cause_d;
  logic              inh_d, flush_d;

  logic [31:0]       off_ext;
  logic [ADDR_W-1:0] off_w;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] seq_pc;

  sign_exten u_sext (
    .imm (bus.branch_offset),
    .ext (off_ext)
  );

  assign off_w  = off_ext[ADDR_W-1:0];
  assign seq_pc = pc_q + STEP;
  assign br_pc  = seq_pc + (off_w << 2);
  // Region bits come from the delay-slot address, as on MIPS.
  assign jmp_pc = {seq_pc[ADDR_W-1:28], bus.jump_target, 2'b00};

  // Single priority chain; lower-priority requests are dropped.
  always_comb begin
    pc_d    = seq_pc;
    epc_d   = epc_q;
    cause_d = cause_q;
    inh_d   = inh_q;
    flush_d = 1'b0;
    if (bus.exception && !inh_q) begin
      pc_d    = EXC_PC;
      epc_d   = pc_q;
      cause_d = CAUSE_EXT;
      inh_d   = 1'b1;
      flush_d = 1'b1;
    end else if (bus.stall) begin
      pc_d    = pc_q;
    end else if (bus.eret && inh_q) begin
      pc_d    = epc_q;
      cause_d = CAUSE_NONE;
      inh_d   = 1'b0;
      flush_d = 1'b1;
    end else if (bus.jump_reg) begin
      flush_d = 1'b1;
      if (bus.reg_target[1:0] == 2'b00) begin
        pc_d    = bus.reg_target;
      end else begin
        pc_d    = EXC_PC;
        cause_d = CAUSE_ADEL;
        inh_d   = 1'b1;
        // Keep the original return point if already in a handler.
        if (!inh_q)
          epc_d = pc_q;
      end
    end else if (bus.jump) begin
      pc_d    = jmp_pc;
      flush_d = 1'b1;
    end else if (bus.branch_taken) begin
      pc_d    = br_pc;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RST_PC;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      inh_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      inh_q   <= inh_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = seq_pc;
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.in_handler = inh_q;
  assign bus.flush      = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Linear steps with hand-computed expectations.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0080)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset             = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 26'h0;
    bus.jump_reg      = 1'b0;
    bus.reg_target    = 32'h0;
    bus.exception     = 1'b0;
    bus.eret          = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic jr(logic [31:0] t);
    bus.jump_reg   = 1'b1;
    bus.reg_target = t;
    tick();
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    tick();
    idle();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pc4", bus.pc_plus4, 32'h4);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_cause", 32'(bus.cause), 32'h0);
    chk("rst_inh", 32'(bus.in_handler), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);

    tick();
    chk("run_pc4", bus.pc, 32'h4);
    chk("run_fl4", 32'(bus.flush), 32'h0);
    tick();
    chk("run_pc8", bus.pc, 32'h8);
    tick();
    chk("run_pc12", bus.pc, 32'hC);
    chk("run_fl12", 32'(bus.flush), 32'h0);

    jr(32'h100);
    chk("jr_pc", bus.pc, 32'h100);
    chk("jr_flush", 32'(bus.flush), 32'h1);

    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'hFFFE;
    tick();
    idle();
    chk("br_neg_pc", bus.pc, 32'hFC);
    chk("br_neg_fl", 32'(bus.flush), 32'h1);
    tick();
    chk("br_after_pc", bus.pc, 32'h100);
    chk("br_after_fl", 32'(bus.flush), 32'h0);

    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0003;
    tick();
    idle();
    chk("br_pos_pc", bus.pc, 32'h110);

    jr(32'h1000_0000);
    bus.jump        = 1'b1;
    bus.jump_target = 26'h0000040;
    tick();
    idle();
    chk("j_pc", bus.pc, 32'h1000_0100);
    chk("j_flush", 32'(bus.flush), 32'h1);

    jr(32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc_plus4, 32'h0);
    tick();
    chk("wrap_pc", bus.pc, 32'h0);

    jr(32'h200);
    bus.exception = 1'b1;
    bus.stall     = 1'b1;
    tick();
    idle();
    chk("exc_pc", bus.pc, 32'h80);
    chk("exc_epc", bus.epc, 32'h200);
    chk("exc_cause", 32'(bus.cause), 32'h1);
    chk("exc_inh", 32'(bus.in_handler), 32'h1);
    chk("exc_flush", 32'(bus.flush), 32'h1);

    bus.exception = 1'b1;
    tick();
    idle();
    chk("exc2_pc", bus.pc, 32'h84);
    chk("exc2_epc", bus.epc, 32'h200);
    chk("exc2_flush", 32'(bus.flush), 32'h0);

    bus.eret = 1'b1;
    tick();
    idle();
    chk("eret_pc", bus.pc, 32'h200);
    chk("eret_inh", 32'(bus.in_handler), 32'h0);
    chk("eret_cause", 32'(bus.cause), 32'h0);
    chk("eret_flush", 32'(bus.flush), 32'h1);

    jr(32'h40);
    jr(32'h302);
    chk("adel_pc", bus.pc, 32'h80);
    chk("adel_cause", 32'(bus.cause), 32'h2);
    chk("adel_epc", bus.epc, 32'h40);
    chk("adel_inh", 32'(bus.in_handler), 32'h1);

    bus.eret = 1'b1;
    tick();
    idle();
    chk("adel_ret_pc", bus.pc, 32'h40);

    bus.stall         = 1'b1;
    bus.jump          = 1'b1;
    bus.jump_target   = 26'h0000040;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0003;
    tick();
    idle();
    chk("stall_pc", bus.pc, 32'h40);
    chk("stall_fl", 32'(bus.flush), 32'h0);

    bus.jump          = 1'b1;
    bus.jump_target   = 26'h0000040;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0003;
    tick();
    idle();
    chk("prio_j_pc", bus.pc, 32'h100);

    bus.exception = 1'b1;
    tick();
    idle();
    chk("rh_inh_pre", 32'(bus.in_handler), 32'h1);
    reset = 1'b1;
    tick();
    idle();
    chk("rh_pc", bus.pc, 32'h0);
    chk("rh_epc", bus.epc, 32'h0);
    chk("rh_cause", 32'(bus.cause), 32'h0);
    chk("rh_inh", 32'(bus.in_handler), 32'h0);
    chk("rh_flush", 32'(bus.flush), 32'h0);

    bus.eret = 1'b1;
    tick();
    idle();
    chk("eret_idle_pc", bus.pc, 32'h4);
    chk("eret_idle_fl", 32'(bus.flush), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
